// File: rtl/ce361_pkg.sv
// rtl/ce361_pkg.sv - opcodes, functs, ALU encodings and FSM states for the multicycle controller
package ce361_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_ADDU = 3'd4;
  localparam logic [2:0] ALU_SLL  = 3'd5;
  localparam logic [2:0] ALU_SUB  = 3'd6;
  localparam logic [2:0] ALU_SLTU = 3'd7;

  // Bit positions in the one-hot instruction vector; R-type occupies 0..8.
  localparam int I_ADD  = 0;
  localparam int I_ADDU = 1;
  localparam int I_SUB  = 2;
  localparam int I_SUBU = 3;
  localparam int I_AND  = 4;
  localparam int I_OR   = 5;
  localparam int I_SLL  = 6;
  localparam int I_SLT  = 7;
  localparam int I_SLTU = 8;
  localparam int I_ADDI = 9;
  localparam int I_LW   = 10;
  localparam int I_SW   = 11;
  localparam int I_BEQ  = 12;
  localparam int I_BNE  = 13;
  localparam int I_BGTZ = 14;
  localparam int NUM_INSTR = 15;

  typedef logic [NUM_INSTR-1:0] instr_vec_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  function automatic logic [2:0] alu_ctr_of(input instr_vec_t v);
    logic [2:0] r;
    r = ALU_AND;
    if (v[I_OR])                                        r = ALU_OR;
    if (v[I_ADD] | v[I_ADDI])                           r = ALU_ADD;
    if (v[I_SLT])                                       r = ALU_SLT;
    if (v[I_ADDU] | v[I_LW] | v[I_SW])                  r = ALU_ADDU;
    if (v[I_SLL])                                       r = ALU_SLL;
    if (v[I_SUB] | v[I_SUBU] | v[I_BEQ] | v[I_BNE] | v[I_BGTZ]) r = ALU_SUB;
    if (v[I_SLTU])                                      r = ALU_SLTU;
    return r;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - maps opcode/funct to a one-hot instruction vector plus illegal flag
module instr_decode
  import ce361_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output instr_vec_t onehot_o,
  output logic       illegal_o
);

  always_comb begin
    onehot_o = '0;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  onehot_o[I_ADD]  = 1'b1;
          FN_ADDU: onehot_o[I_ADDU] = 1'b1;
          FN_SUB:  onehot_o[I_SUB]  = 1'b1;
          FN_SUBU: onehot_o[I_SUBU] = 1'b1;
          FN_AND:  onehot_o[I_AND]  = 1'b1;
          FN_OR:   onehot_o[I_OR]   = 1'b1;
          FN_SLL:  onehot_o[I_SLL]  = 1'b1;
          FN_SLT:  onehot_o[I_SLT]  = 1'b1;
          FN_SLTU: onehot_o[I_SLTU] = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: onehot_o[I_ADDI] = 1'b1;
      OP_LW:   onehot_o[I_LW]   = 1'b1;
      OP_SW:   onehot_o[I_SW]   = 1'b1;
      OP_BEQ:  onehot_o[I_BEQ]  = 1'b1;
      OP_BNE:  onehot_o[I_BNE]  = 1'b1;
      OP_BGTZ: onehot_o[I_BGTZ] = 1'b1;
      default: ;
    endcase
  end

  assign illegal_o = ~|onehot_o;

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle control FSM owning PC, IR and the memory wait timeout
module multicycle_control
  import ce361_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  input  logic            equal,
  input  logic            sign,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] pc,
  output logic            RegWr,
  output logic            RegDst,
  output logic            ExtOp,
  output logic            ALUSrc,
  output logic [2:0]      ALUctr,
  output logic            MemtoReg,
  output logic            illegal,
  output logic            fault
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [31:0]      ir_q;
  logic [CNT_W-1:0] wait_q;
  logic             illegal_q;
  logic             fault_q;

  instr_vec_t       dec;
  logic             dec_illegal;
  logic             is_rtype;
  logic             is_branch;
  logic             br_taken;
  logic             active;
  logic             timeout_hit;
  logic [PC_W-1:0]  pc_inc_d;
  logic [PC_W-1:0]  br_target_d;

  instr_decode u_decode (
    .op_i      (ir_q[31:26]),
    .funct_i   (ir_q[5:0]),
    .onehot_o  (dec),
    .illegal_o (dec_illegal)
  );

  assign is_rtype  = |dec[I_SLTU:I_ADD];
  assign is_branch = dec[I_BEQ] | dec[I_BNE] | dec[I_BGTZ];
  assign br_taken  = (dec[I_BEQ] & equal) | (dec[I_BNE] & ~equal) | (dec[I_BGTZ] & ~(equal | sign));

  // pc already points past the branch when EXEC runs, so the offset is added to pc+4.
  assign pc_inc_d    = pc_q + PC_W'(4);
  assign br_target_d = pc_q + PC_W'({{14{ir_q[15]}}, ir_q[15:0], 2'b00});

  assign timeout_hit = (TIMEOUT != 0) && (32'(wait_q) == TIMEOUT - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            ir_q    <= imem_rdata;
            pc_q    <= pc_inc_d;
            wait_q  <= '0;
            state_q <= S_DECODE;
          end else if (timeout_hit) begin
            fault_q <= 1'b1;
            wait_q  <= '0;
            state_q <= S_HALT;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            illegal_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_branch) begin
            if (br_taken) pc_q <= br_target_d;
            state_q <= S_FETCH;
          end else if (dec[I_LW] | dec[I_SW]) begin
            state_q <= S_MEM;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            wait_q  <= '0;
            state_q <= dec[I_LW] ? S_WB : S_FETCH;
          end else if (timeout_hit) begin
            fault_q <= 1'b1;
            wait_q  <= '0;
            state_q <= S_HALT;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        S_WB:    state_q <= S_FETCH;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Reset forces FETCH, so imem_req is the only output that must be masked by reset itself.
  assign active    = (state_q == S_DECODE) | (state_q == S_EXEC) | (state_q == S_MEM) | (state_q == S_WB);
  assign imem_req  = (state_q == S_FETCH) & ~reset;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign inst      = ir_q;
  assign dmem_req  = (state_q == S_MEM);
  assign dmem_we   = (state_q == S_MEM) & dec[I_SW];
  assign RegWr     = (state_q == S_WB);
  assign RegDst    = active & is_rtype;
  assign ALUSrc    = active & ~dec_illegal & ~is_rtype;
  assign ExtOp     = active & (dec[I_ADDI] | dec[I_LW] | dec[I_SW]);
  assign MemtoReg  = active & dec[I_LW];
  assign ALUctr    = active ? alu_ctr_of(dec) : 3'd0;
  assign illegal   = illegal_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam logic [31:0] RST_PC = 32'h40;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        equal;
  logic        sign;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        RegWr;
  logic        RegDst;
  logic        ExtOp;
  logic        ALUSrc;
  logic [2:0]  ALUctr;
  logic        MemtoReg;
  logic        illegal;
  logic        fault;

  int          n_checks;
  int          n_errors;
  logic [31:0] mpc;

  multicycle_control #(.PC_W(32), .RESET_PC(RST_PC), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .equal(equal), .sign(sign), .inst(inst), .pc(pc),
    .RegWr(RegWr), .RegDst(RegDst), .ExtOp(ExtOp), .ALUSrc(ALUSrc), .ALUctr(ALUctr),
    .MemtoReg(MemtoReg), .illegal(illegal), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] alu;
    logic       rtype;
    logic       extop;
    logic       memtoreg;
    logic       lw;
    logic       sw;
    logic       br;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instruction table: what each legal word means to the controller.
  function automatic exp_t model_decode(input logic [31:0] w);
    exp_t e;
    e = '0;
    case (w[31:26])
      6'h00: begin
        e.rtype = 1'b1;
        case (w[5:0])
          6'h20: e.alu = 3'd2;
          6'h21: e.alu = 3'd4;
          6'h22, 6'h23: e.alu = 3'd6;
          6'h24: e.alu = 3'd0;
          6'h25: e.alu = 3'd1;
          6'h00: e.alu = 3'd5;
          6'h2a: e.alu = 3'd3;
          6'h2b: e.alu = 3'd7;
          default: e.rtype = 1'b0;
        endcase
      end
      6'h08: begin e.alu = 3'd2; e.extop = 1'b1; end
      6'h23: begin e.alu = 3'd4; e.extop = 1'b1; e.memtoreg = 1'b1; e.lw = 1'b1; end
      6'h2b: begin e.alu = 3'd4; e.extop = 1'b1; e.sw = 1'b1; end
      6'h04, 6'h05, 6'h07: begin e.alu = 3'd6; e.br = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_word(input int k, input logic [31:0] r);
    logic [5:0] op;
    logic [5:0] fn;
    op = 6'h00;
    fn = 6'h00;
    case (k)
      0: fn = 6'h20;  1: fn = 6'h21;  2: fn = 6'h22;  3: fn = 6'h23;  4: fn = 6'h24;
      5: fn = 6'h25;  6: fn = 6'h00;  7: fn = 6'h2a;  8: fn = 6'h2b;
      9: op = 6'h08; 10: op = 6'h23; 11: op = 6'h2b; 12: op = 6'h04; 13: op = 6'h05;
      default: op = 6'h07;
    endcase
    if (k <= 8) return {6'h00, r[25:6], fn};
    return {op, r[25:0]};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_regwr", RegWr, 0);
    check("rst_aluctr", ALUctr, 0);
    check("rst_pc", pc, RST_PC);
    check("rst_inst", inst, 0);
    check("rst_illegal", illegal, 0);
    check("rst_fault", fault, 0);
    repeat (2) @(negedge clk);
    check("rst_hold_imem_req", imem_req, 0);
    reset = 1'b0;
    #1;
    check("first_imem_req", imem_req, 1);
    check("first_imem_addr", imem_addr, RST_PC);
    mpc = RST_PC;
  endtask

  // Runs one instruction from FETCH entry to the next FETCH entry against the model.
  task automatic run_instr(input logic [31:0] w, input int fd, input int md,
                           input logic eq, input logic sg, input bit abort_mem);
    exp_t        e;
    logic [31:0] pc_next;
    logic        taken;
    int          exp_cyc;
    int          cyc, fw, mw, n_wr, n_dm, n_we;
    bit          got, ack_prev;
    e = model_decode(w);
    taken = (w[31:26] == 6'h04) ? eq : (w[31:26] == 6'h05) ? !eq : !(eq | sg);
    pc_next = mpc + 32'd4;
    if (e.br && taken) pc_next = pc_next + {{14{w[15]}}, w[15:0], 2'b00};
    exp_cyc = fd + 3 + (e.br ? 0 : e.lw ? md + 2 : e.sw ? md + 1 : 1);
    cyc = 0; fw = 0; mw = 0; n_wr = 0; n_dm = 0; n_we = 0;
    got = 0; ack_prev = 0;
    equal = eq;
    sign = sg;
    check("fetch_addr", imem_addr, mpc);
    while (1) begin
      if (got && imem_req) break;
      if (cyc > 60) begin
        check("cycle_budget", cyc, exp_cyc);
        return;
      end
      if (ack_prev) begin
        check("dec_inst", inst, w);
        check("dec_pc", pc, mpc + 32'd4);
        check("dec_aluctr", ALUctr, e.alu);
        check("dec_regdst", RegDst, e.rtype);
        check("dec_alusrc", ALUSrc, !e.rtype);
        check("dec_extop", ExtOp, e.extop);
        check("dec_memtoreg", MemtoReg, e.memtoreg);
      end
      ack_prev = 0;
      if (abort_mem && dmem_req && mw == 1) begin
        dmem_ack = 1'b0;
        return;
      end
      n_wr += int'(RegWr);
      if (dmem_req) begin
        n_dm++;
        n_we += int'(dmem_we);
      end
      if (imem_req) begin
        imem_ack = (fw == fd);
        imem_rdata = (fw == fd) ? w : $urandom;
        if (fw == fd) begin
          got = 1;
          ack_prev = 1;
        end
        fw++;
      end else begin
        imem_ack = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
      end
      if (dmem_req) begin
        dmem_ack = (mw == md);
        mw++;
      end else begin
        dmem_ack = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    check("instr_cycles", cyc, exp_cyc);
    check("next_imem_addr", imem_addr, pc_next);
    check("regwr_pulses", n_wr, (e.br || e.sw) ? 0 : 1);
    check("dmem_req_cycles", n_dm, (e.lw || e.sw) ? md + 1 : 0);
    check("dmem_we_cycles", n_we, e.sw ? md + 1 : 0);
    mpc = pc_next;
  endtask

  task automatic run_illegal(input logic [31:0] w);
    int n_req, n_wr, n_dm;
    n_req = 0; n_wr = 0; n_dm = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) check("illegal_in_decode", illegal, 0);
      if (c == 2) check("illegal_after_decode", illegal, 1);
      n_req += int'(imem_req);
      n_wr  += int'(RegWr);
      n_dm  += int'(dmem_req);
      imem_ack = 1'b1;
      imem_rdata = w;
      dmem_ack = 1'b1;
      @(negedge clk);
    end
    check("illegal_flag", illegal, 1);
    check("illegal_fault", fault, 0);
    check("illegal_fetches", n_req, 1);
    check("illegal_regwr", n_wr, 0);
    check("illegal_dmem", n_dm, 0);
    check("illegal_pc", pc, RST_PC + 32'd4);
    check("illegal_inst", inst, w);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    dmem_ack = 1'b0;
    equal = 1'b0;
    sign = 1'b0;
    n_checks = 0;
    n_errors = 0;
    mpc = RST_PC;
    @(negedge clk);
    do_reset();

    run_instr(32'h00221820, 0, 0, 1'b0, 1'b0, 0);
    run_instr(32'h1000FFFF, 0, 0, 1'b1, 1'b0, 0);
    run_instr(32'h8C220004, 0, 3, 1'b0, 1'b0, 0);
    run_instr(32'hAC220008, 1, 0, 1'b0, 1'b0, 0);
    run_instr(32'h14220002, 0, 0, 1'b1, 1'b0, 0);
    run_instr(32'h1C200003, 2, 0, 1'b0, 1'b0, 0);
    run_instr(32'h1C200003, 0, 0, 1'b0, 1'b1, 0);
    run_instr(32'h00000000, 3, 0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 80; i++)
      run_instr(rand_word(int'($urandom_range(0, 14)), $urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

    run_instr(32'hAC220008, 0, 3, 1'b0, 1'b0, 1);
    check("sw_mem_req", dmem_req, 1);
    check("sw_mem_we", dmem_we, 1);
    do_reset();
    run_instr(32'h00221820, 0, 0, 1'b0, 1'b0, 0);

    do_reset();
    imem_ack = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (!imem_req) break;
      n++;
      @(negedge clk);
    end
    check("timeout_fetch_cycles", n, 4);
    check("timeout_fault", fault, 1);
    check("timeout_imem_req", imem_req, 0);
    check("timeout_illegal", illegal, 0);
    repeat (5) begin
      imem_ack = 1'b1;
      @(negedge clk);
    end
    check("halt_imem_req", imem_req, 0);
    check("halt_pc", pc, RST_PC);
    check("halt_fault", fault, 1);
    check("halt_regwr", RegWr, 0);

    do_reset();
    run_illegal(32'hFC000000);
    do_reset();
    run_illegal(32'h0000003F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter PC_W, default 32: width of program counter and imem_addr (16..32).
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 Parameter TIMEOUT, default 16: maximum cycles a memory request may wait for ack; 0 disables the timeout.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high. Ports are clk (in, 1, rising-edge clock) and reset (in, 1, asynchronous active-high reset).
REQ-005 Instruction memory ports:
- imem_req out 1: instruction fetch request.
- imem_addr out PC_W: fetch address, equal to pc.
- imem_rdata in 32: instruction word.
- imem_ack in 1: fetch data valid.
REQ-006 Data memory ports:
- dmem_req out 1: data access request.
- dmem_we out 1: write access when high (sw).
- dmem_ack in 1: data access complete.
REQ-007 Datapath status inputs:
- equal in 1: ALU zero flag.
- sign in 1: ALU result bit 31.
REQ-008 Datapath outputs:
- inst out 32: instruction register (IR).
- pc out PC_W: current PC.
REQ-009 Control outputs:
- RegWr out 1
- RegDst out 1
- ExtOp out 1
- ALUSrc out 1
- ALUctr out 3
- MemtoReg out 1
REQ-010 Status outputs:
- illegal out 1: sticky flag, unknown opcode or funct.
- fault out 1: sticky flag, memory timeout.

Function
REQ-011 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-012 FETCH behaviour:
- imem_req=1.
- On imem_ack: IR<=imem_rdata, pc<=pc+4 (modulo 2^PC_W), go to DECODE.
- Without ack: remain in FETCH.
REQ-013 DECODE: one cycle. An illegal instruction sets illegal=1 and goes to HALT; otherwise go to EXEC.
REQ-014 Supported instructions:
- R-type (op 000000): funct add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, sll 000000, slt 101010, sltu 101011.
- I-type: addi 001000, lw 100011, sw 101011, beq 000100, bne 000101, bgtz 000111.
REQ-015 ALUctr encoding:
- and=0, or=1, add/addi=2, slt=3.
- addu/lw/sw=4, sll=5.
- sub/subu/beq/bne/bgtz=6, sltu=7.
REQ-016 In DECODE, EXEC, MEM and WB: ALUctr, ALUSrc, ExtOp, RegDst and MemtoReg are driven from IR.
- RegDst=1 for R-type only.
- ALUSrc=!RegDst.
- ExtOp=1 for addi, lw, sw.
- MemtoReg=1 for lw.
- In FETCH and HALT all control outputs are 0.
REQ-017 EXEC branch handling, using equal/sign sampled in EXEC:
- Taken when: beq and equal; bne and !equal; bgtz and !(equal|sign).
- If taken: pc<=pc+(sext(imm16)<<2), truncated to PC_W.
- Branches then go to FETCH.
REQ-018 EXEC next state: lw and sw go to MEM; every other non-branch instruction goes to WB.
REQ-019 MEM:
- dmem_req=1, dmem_we=1 only for sw.
- On dmem_ack: lw goes to WB, sw goes to FETCH.
REQ-020 WB: RegWr=1 for exactly one cycle, then go to FETCH. RegWr is 0 in every other state.
REQ-021 Acks:
- An ack in the same cycle the request is first asserted is accepted.
- An ack while the corresponding req=0 is ignored.
REQ-022 Latency with zero-wait memories, measured from FETCH entry to the next FETCH entry:
- R-type/addi: 4 cycles.
- lw: 5 cycles.
- sw: 4 cycles.
- Branch (taken or not): 3 cycles.
REQ-023 Timeout:
- A wait counter clears on each state entry and increments each FETCH/MEM cycle without ack.
- When TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack: set fault=1, go to HALT, deassert req.
REQ-024 HALT:
- All requests and control outputs are 0; pc and inst hold.
- HALT is left only by reset.

Reset
REQ-025 While reset=1:
- state=FETCH, pc=RESET_PC, inst=0, wait counter=0, illegal=0, fault=0.
- All outputs are 0, including imem_req.
REQ-026 Reset asserted mid-operation (any state, including during a pending req) takes effect immediately; no memory write completes after reset assertion.
REQ-027 The first imem_req is asserted in the first cycle after reset deasserts.

Structure
REQ-028 Shared package ce361_pkg holds:
- Opcode and funct constants.
- ALUctr encodings.
- State enum.
REQ-029 One combinational sub-module, instr_decode, maps IR to a one-hot instruction vector plus an illegal flag. The FSM, pc, IR and wait counter live in multicycle_control.

Verification
REQ-030 Reset, then R-type add (0x00221820) with immediate acks -> RegWr=1 only in cycle 4, ALUctr=2, RegDst=1, pc=4.
REQ-031 beq taken (0x1000FFFF, equal=1) at pc=8 -> pc=8 after EXEC (8+4-4), next imem_addr=8, total 3 cycles.
REQ-032 lw with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, MemtoReg=1, RegWr pulses once after ack, 8 cycles total.
REQ-033 TIMEOUT=4, imem_ack never asserted -> fault=1 after 4 FETCH cycles, imem_req=0, HALT until reset.
REQ-034 Opcode 0x3F fetched -> illegal=1 after DECODE, no RegWr/dmem_req ever, state HALT.
REQ-035 Reset asserted during MEM of sw with dmem_req=1 -> dmem_req and dmem_we drop the same cycle, pc=RESET_PC, fetch restarts after release.
